param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 8, number of storage entries (power of two, >=2).
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries (1..DEPTH-1).
REQ-004 SHALL derive localparam AW = log2(DEPTH) and CW = AW+1.
REQ-005 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 wen  input  1  write request; din captured on the edge when accepted.
REQ-009 ren  input  1  read request; oldest entry presented on dout one cycle later.
REQ-010 clr_err  input  1  clears sticky ovf/udf flags.
REQ-011 din  input  DATA_W  write data.
REQ-012 dout  output  DATA_W  registered read data.
REQ-013 error  output  1  one-cycle pulse after any rejected request.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 almost_full  output  1  count >= AF_LEVEL.
REQ-017 count  output  CW  current occupancy, 0..DEPTH.
REQ-018 ovf  output  1  sticky: a write was rejected since last clear.
REQ-019 udf  output  1  sticky: a read was rejected since last clear.

Function
REQ-020 Storage SHALL be DEPTH x DATA_W; write and read pointers of AW bits SHALL wrap from DEPTH-1 to 0.
REQ-021 Write accepted iff wen && (!full || ren); accepted write stores din at wptr, wptr+1.
REQ-022 Read accepted iff ren && !empty; accepted read loads mem[rptr] into dout at that edge, rptr+1.
REQ-023 When full with wen && ren, both SHALL be accepted; count unchanged; dout gets the oldest entry, not din.
REQ-024 When empty with wen && ren, write SHALL be accepted and read rejected (no fall-through); count becomes 1.
REQ-025 count SHALL be +1 on accepted write only, -1 on accepted read only, unchanged otherwise; never outside 0..DEPTH.
REQ-026 dout SHALL hold its value on any cycle without an accepted read.
REQ-027 Rejected write (wen && full && !ren) SHALL not modify memory, pointers or count; error=1 next cycle; ovf set.
REQ-028 Rejected read (ren && empty) SHALL not modify pointers or dout; error=1 next cycle; udf set.
REQ-029 error SHALL be 0 in any cycle not following a rejection; back-to-back rejections SHALL keep error high.
REQ-030 clr_err SHALL clear ovf/udf at the edge; a rejection in the same cycle SHALL win (flag set).
REQ-031 full, empty, almost_full SHALL be decoded from registered count, valid in the same cycle as count.

Reset
REQ-032 On rst high at an edge: wptr=0, rptr=0, count=0, dout=0, error=0, ovf=0, udf=0; memory contents need not be cleared.
REQ-033 rst SHALL take priority over wen, ren, clr_err; requests in a reset cycle SHALL be ignored and SHALL NOT raise error.
REQ-034 After reset: empty=1, full=0, almost_full=0.

Verification
REQ-035 Reset, write 1,2, read x3 -> dout 1 then 2; third read: dout holds 2, error=1 one cycle, udf=1.
REQ-036 DEPTH=8: write 9 words 3..11 -> count 8, full=1 after 8th, almost_full=1 from count 6; 9th rejected, error pulse, ovf=1, then read 8 -> dout 3..10 in order.
REQ-037 Full FIFO, wen&&ren with din=0xAA -> dout = oldest word, count stays 8, no error; 0xAA read out last.
REQ-038 Empty FIFO, wen&&ren din=0x55 -> error=1, udf=1, count=1; next read -> dout=0x55.
REQ-039 Reset asserted mid-stream with count=5 -> count=0, dout=0, flags cleared; clr_err with simultaneous rejected read -> udf remains 1.
REQ-040 Parameter sweep DATA_W=16, DEPTH=4, AF_LEVEL=3 -> pointer wrap across 3 fill/drain cycles with data order preserved.

Source files
------------

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if -- request/status bundle for param_sync_fifo.
//   master : drives wen, ren, clr_err and din; observes dout and status
//   slave  : the FIFO side, which drives dout, error, full, empty,
//            almost_full, count, ovf and udf
// DATA_W and DEPTH must match the parameters of the attached FIFO.
interface param_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wen;
  logic              ren;
  logic              clr_err;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              error;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              udf;

  modport master (
    output wen, ren, clr_err, din,
    input  dout, error, full, empty, almost_full, count, ovf, udf
  );

  modport slave (
    input  wen, ren, clr_err, din,
    output dout, error, full, empty, almost_full, count, ovf, udf
  );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo -- single-clock FIFO with registered read data,
// occupancy count, almost_full threshold and sticky overflow/underflow.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : param_sync_fifo_if.slave
//         wen/din      write request and data
//         ren          read request, oldest entry lands on dout next cycle
//         clr_err      clears the sticky ovf/udf flags
//         dout         registered read data, held when no read is accepted
//         error        one-cycle pulse after any rejected request
//         full/empty/almost_full decoded from the registered count
//         count        occupancy 0..DEPTH
//         ovf/udf      sticky rejected-write / rejected-read flags
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic              clk,
  input logic              rst,
  param_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wptr_q,  wptr_d;
  logic [AW-1:0]     rptr_q,  rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              error_q, error_d;
  logic              ovf_q,   ovf_d;
  logic              udf_q,   udf_d;

  logic full, empty;
  logic wr_acc, rd_acc, wr_rej, rd_rej;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    // When full, a simultaneous read frees a slot in the same edge, so the
    // write may proceed. When empty the read is rejected even if a write
    // arrives: there is no fall-through path to dout.
    wr_acc = bus.wen && (!full || bus.ren);
    rd_acc = bus.ren && !empty;
    wr_rej = bus.wen && !wr_acc;
    rd_rej = bus.ren && !rd_acc;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;

    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
      dout_d = mem_q[rptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    error_d = wr_rej || rd_rej;
    // A rejection in the same cycle as clr_err leaves the flag set.
    ovf_d   = wr_rej || (ovf_q && !bus.clr_err);
    udf_d   = rd_rej || (udf_q && !bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      error_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      error_q <= error_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset; writes requested during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q] <= bus.din;
  end

  assign bus.dout        = dout_q;
  assign bus.error       = error_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count_q >= AF_CNT);
  assign bus.count       = count_q;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_W(8),  .DEPTH(8)) bus8 ();
  param_sync_fifo_if #(.DATA_W(16), .DEPTH(4)) bus4 ();

  param_sync_fifo #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  param_sync_fifo #(.DATA_W(16), .DEPTH(4), .AF_LEVEL(3)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Apply one cycle of requests to the DEPTH=8 instance, sample 1ns after the edge.
  task automatic op8(input logic w, input logic r, input logic c, input logic [7:0] d);
    bus8.wen = w; bus8.ren = r; bus8.clr_err = c; bus8.din = d;
    @(posedge clk); #1;
    bus8.wen = 1'b0; bus8.ren = 1'b0; bus8.clr_err = 1'b0;
  endtask

  task automatic op4(input logic w, input logic r, input logic [15:0] d);
    bus4.wen = w; bus4.ren = r; bus4.clr_err = 1'b0; bus4.din = d;
    @(posedge clk); #1;
    bus4.wen = 1'b0; bus4.ren = 1'b0;
  endtask

  initial begin
    bus8.wen = 1'b0; bus8.ren = 1'b0; bus8.clr_err = 1'b0; bus8.din = '0;
    bus4.wen = 1'b0; bus4.ren = 1'b0; bus4.clr_err = 1'b0; bus4.din = '0;

    // reset, with requests present that must be ignored
    rst = 1'b1;
    bus8.wen = 1'b1; bus8.ren = 1'b1; bus8.din = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    bus8.wen = 1'b0; bus8.ren = 1'b0;
    rst = 1'b0;
    check("rst_count", bus8.count, 0);
    check("rst_empty", bus8.empty, 1);
    check("rst_full",  bus8.full, 0);
    check("rst_af",    bus8.almost_full, 0);
    check("rst_dout",  bus8.dout, 0);
    check("rst_error", bus8.error, 0);
    check("rst_ovf",   bus8.ovf, 0);
    check("rst_udf",   bus8.udf, 0);
    check("rst4_empty", bus4.empty, 1);

    // write 1,2 then read three times
    op8(1, 0, 0, 8'd1);
    op8(1, 0, 0, 8'd2);
    check("wr2_count", bus8.count, 2);
    op8(0, 1, 0, 8'd0);
    check("rd1_dout", bus8.dout, 1);
    check("rd1_err",  bus8.error, 0);
    op8(0, 1, 0, 8'd0);
    check("rd2_dout", bus8.dout, 2);
    check("rd2_empty", bus8.empty, 1);
    op8(0, 1, 0, 8'd0);
    check("rd3_dout_hold", bus8.dout, 2);
    check("rd3_err", bus8.error, 1);
    check("rd3_udf", bus8.udf, 1);
    op8(0, 0, 0, 8'd0);
    check("idle_err_drop", bus8.error, 0);
    check("idle_udf_sticky", bus8.udf, 1);
    op8(0, 0, 1, 8'd0);
    check("clr_udf", bus8.udf, 0);

    // write 3..11: count, almost_full from 6, full at 8, 9th rejected
    for (int i = 1; i <= 8; i++) begin
      op8(1, 0, 0, 8'(i + 2));
      check("fill_count", bus8.count, i);
      check("fill_af",    bus8.almost_full, (i >= 6) ? 1 : 0);
      check("fill_full",  bus8.full, (i == 8) ? 1 : 0);
    end
    op8(1, 0, 0, 8'd11);
    check("ovf_count", bus8.count, 8);
    check("ovf_err",   bus8.error, 1);
    check("ovf_flag",  bus8.ovf, 1);
    op8(0, 0, 0, 8'd0);
    check("ovf_err_drop", bus8.error, 0);
    for (int i = 0; i < 8; i++) begin
      op8(0, 1, 0, 8'd0);
      check("drain_dout",  bus8.dout, i + 3);
      check("drain_count", bus8.count, 7 - i);
    end
    check("drain_empty", bus8.empty, 1);
    op8(0, 0, 1, 8'd0);
    check("clr_ovf", bus8.ovf, 0);

    // full FIFO with simultaneous read and write
    for (int i = 0; i < 8; i++) op8(1, 0, 0, 8'(8'h20 + i));
    check("full2", bus8.full, 1);
    op8(1, 1, 0, 8'hAA);
    check("fwr_dout",  bus8.dout, 8'h20);
    check("fwr_count", bus8.count, 8);
    check("fwr_err",   bus8.error, 0);
    for (int i = 1; i < 8; i++) begin
      op8(0, 1, 0, 8'd0);
      check("fwr_drain", bus8.dout, 8'h20 + i);
    end
    op8(0, 1, 0, 8'd0);
    check("fwr_last", bus8.dout, 8'hAA);
    check("fwr_empty", bus8.empty, 1);

    // empty FIFO with simultaneous read and write: no fall-through
    op8(1, 1, 0, 8'h55);
    check("ewr_err",   bus8.error, 1);
    check("ewr_udf",   bus8.udf, 1);
    check("ewr_count", bus8.count, 1);
    check("ewr_dout",  bus8.dout, 8'hAA);
    op8(0, 1, 0, 8'd0);
    check("ewr_read", bus8.dout, 8'h55);
    check("ewr_err2", bus8.error, 0);

    // reset mid-stream with count 5 and a pending write
    for (int i = 1; i <= 5; i++) op8(1, 0, 0, 8'(i));
    check("mid_count", bus8.count, 5);
    rst = 1'b1;
    op8(1, 0, 0, 8'h77);
    rst = 1'b0;
    check("mid_rst_count", bus8.count, 0);
    check("mid_rst_dout",  bus8.dout, 0);
    check("mid_rst_udf",   bus8.udf, 0);
    check("mid_rst_err",   bus8.error, 0);
    check("mid_rst_empty", bus8.empty, 1);
    op8(0, 1, 0, 8'd0);
    check("udf_again", bus8.udf, 1);
    op8(0, 1, 1, 8'd0);
    check("clr_vs_rej_udf", bus8.udf, 1);
    check("clr_vs_rej_err", bus8.error, 1);
    op8(0, 0, 1, 8'd0);
    check("clr_final", bus8.udf, 0);

    // DATA_W=16, DEPTH=4: partial fill/drain rounds walk pointers across the wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) op4(1, 0, 16'(16'hA000 + r * 16 + i));
      check("w4_count", bus4.count, 3);
      check("w4_af",    bus4.almost_full, 1);
      check("w4_full",  bus4.full, 0);
      for (int i = 0; i < 3; i++) begin
        op4(0, 1, 16'd0);
        check("w4_dout", bus4.dout, 16'hA000 + r * 16 + i);
      end
      check("w4_empty", bus4.empty, 1);
    end
    for (int i = 0; i < 4; i++) op4(1, 0, 16'(16'hB000 + i));
    check("w4_full4", bus4.full, 1);
    for (int i = 0; i < 4; i++) begin
      op4(0, 1, 16'd0);
      check("w4_fdout", bus4.dout, 16'hB000 + i);
    end
    check("w4_err", bus4.error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
